// File: rtl/reg_file_rename_if.sv
// Dispatcher / ROB-commit bus of the rename register file.
// master: dispatcher + ROB side, slave: reg_file_rename.
interface reg_file_rename_if #(
  parameter int REG_WIDTH  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 4
);
  logic [REG_WIDTH-1:0]  rs1_idx_in;
  logic [REG_WIDTH-1:0]  rs2_idx_in;
  logic                  rs1_busy_out;
  logic [ROB_WIDTH-1:0]  rs1_rob_out;
  logic [DATA_WIDTH-1:0] rs1_val_out;
  logic                  rs2_busy_out;
  logic [ROB_WIDTH-1:0]  rs2_rob_out;
  logic [DATA_WIDTH-1:0] rs2_val_out;
  logic                  rename_en_in;
  logic [REG_WIDTH-1:0]  rename_rd_in;
  logic [ROB_WIDTH-1:0]  rename_rob_in;
  logic                  commit_en_in;
  logic [REG_WIDTH-1:0]  commit_rd_in;
  logic [DATA_WIDTH-1:0] commit_val_in;
  logic [ROB_WIDTH-1:0]  commit_rob_in;
  logic                  refresh_in;

  modport master (
    output rs1_idx_in, rs2_idx_in,
    input  rs1_busy_out, rs1_rob_out, rs1_val_out,
    input  rs2_busy_out, rs2_rob_out, rs2_val_out,
    output rename_en_in, rename_rd_in, rename_rob_in,
    output commit_en_in, commit_rd_in, commit_val_in, commit_rob_in,
    output refresh_in
  );

  modport slave (
    input  rs1_idx_in, rs2_idx_in,
    output rs1_busy_out, rs1_rob_out, rs1_val_out,
    output rs2_busy_out, rs2_rob_out, rs2_val_out,
    input  rename_en_in, rename_rd_in, rename_rob_in,
    input  commit_en_in, commit_rd_in, commit_val_in, commit_rob_in,
    input  refresh_in
  );
endinterface

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags.
// Reads are combinational; rename/commit/refresh update state on clk_in.
// Optional macro REGFILE_BYPASS_EN: forward a matching commit straight to
// the read ports in the commit cycle.

// One read port: looks up busy/tag/value for idx, x0 hardwired to zero.
module reg_file_rename_rd_port #(
  parameter int REG_NUM    = 32,
  parameter int REG_WIDTH  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 4
) (
  input  logic [REG_WIDTH-1:0]                  idx,
  input  logic [REG_NUM-1:0]                    busy_q,
  input  logic [REG_NUM-1:0][ROB_WIDTH-1:0]     tag_q,
  input  logic [REG_NUM-1:0][DATA_WIDTH-1:0]    val_q,
  input  logic                                  cm_en,
  input  logic [REG_WIDTH-1:0]                  cm_rd,
  input  logic [ROB_WIDTH-1:0]                  cm_rob,
  input  logic [DATA_WIDTH-1:0]                 cm_val,
  output logic                                  busy,
  output logic [ROB_WIDTH-1:0]                  rob,
  output logic [DATA_WIDTH-1:0]                 val
);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic hit;

  // Commit forwarding hit: the commit retires exactly the producer we wait on.
  always_comb begin
    hit = cm_en && (cm_rd == idx) && busy_q[idx] && (tag_q[idx] == cm_rob);
  end

  // Lookup, with x0 forced to "ready, zero" and optional commit forwarding.
  always_comb begin
    busy = 1'b0;
    rob  = '0;
    val  = '0;
    if (idx != '0) begin
      busy = busy_q[idx];
      rob  = busy_q[idx] ? tag_q[idx] : '0;
      val  = val_q[idx];
      if (BYPASS && hit) begin
        busy = 1'b0;
        rob  = '0;
        val  = cm_val;
      end
    end
  end
endmodule

module reg_file_rename #(
  parameter int REG_NUM    = 32,
  parameter int REG_WIDTH  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  reg_file_rename_if.slave  bus
);
  localparam int NUM_PORTS = 2;

  logic [REG_NUM-1:0]                 busy_q;
  logic [REG_NUM-1:0][ROB_WIDTH-1:0]  tag_q;
  logic [REG_NUM-1:0][DATA_WIDTH-1:0] val_q;

  logic [NUM_PORTS-1:0][REG_WIDTH-1:0]  rd_idx;
  logic [NUM_PORTS-1:0]                 rd_busy;
  logic [NUM_PORTS-1:0][ROB_WIDTH-1:0]  rd_rob;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rd_val;

  logic cm_fire;
  logic rn_fire;

  // Qualified requests; x0 is never written or renamed.
  always_comb begin
    cm_fire = rdy_in && bus.commit_en_in && (bus.commit_rd_in != '0);
    rn_fire = rdy_in && bus.rename_en_in && (bus.rename_rd_in != '0)
              && !bus.refresh_in;
  end

  // State update: commit writes value and retires a matching tag; refresh
  // clears all tags (dropping any rename); a rename in the same cycle as a
  // commit to the same rd is applied last so it wins.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q <= '0;
      tag_q  <= '0;
      val_q  <= '0;
    end else if (rdy_in) begin
      if (cm_fire) begin
        val_q[bus.commit_rd_in] <= bus.commit_val_in;
        if (tag_q[bus.commit_rd_in] == bus.commit_rob_in) begin
          busy_q[bus.commit_rd_in] <= 1'b0;
          tag_q[bus.commit_rd_in]  <= '0;
        end
      end
      if (bus.refresh_in) begin
        busy_q <= '0;
        tag_q  <= '0;
      end else if (rn_fire) begin
        busy_q[bus.rename_rd_in] <= 1'b1;
        tag_q[bus.rename_rd_in]  <= bus.rename_rob_in;
      end
    end
  end

  // Gather read indices into lanes.
  always_comb begin
    rd_idx[0] = bus.rs1_idx_in;
    rd_idx[1] = bus.rs2_idx_in;
  end

  for (genvar l = 0; l < NUM_PORTS; l++) begin : g_rd
    reg_file_rename_rd_port #(
      .REG_NUM   (REG_NUM),
      .REG_WIDTH (REG_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .ROB_WIDTH (ROB_WIDTH)
    ) u_rd (
      .idx   (rd_idx[l]),
      .busy_q(busy_q),
      .tag_q (tag_q),
      .val_q (val_q),
      .cm_en (cm_fire),
      .cm_rd (bus.commit_rd_in),
      .cm_rob(bus.commit_rob_in),
      .cm_val(bus.commit_val_in),
      .busy  (rd_busy[l]),
      .rob   (rd_rob[l]),
      .val   (rd_val[l])
    );
  end

  // Scatter lane results to the bus.
  always_comb begin
    bus.rs1_busy_out = rd_busy[0];
    bus.rs1_rob_out  = rd_rob[0];
    bus.rs1_val_out  = rd_val[0];
    bus.rs2_busy_out = rd_busy[1];
    bus.rs2_rob_out  = rd_rob[1];
    bus.rs2_val_out  = rd_val[1];
  end
endmodule
